// File: rtl/fifo_status_reader.sv
// Counts FIFO overflow/underflow flag assertions and hands a snapshot to the host over valid/ack, then clears the monitor.
// Optional: define FIFO_STATUS_TIMESTAMP_EN to append a 16-bit first-overflow timestamp to status_word.

// state     | meaning
// S_IDLE    | waiting for rd_req
// S_PRESENT | status_word valid, waiting for status_ack
// S_CLEAR   | clear_out high for CLR_CYCLES cycles
// S_HOLD    | waiting HOLDOFF cycles for the monitor flags to drop
module fifo_status_reader #(
  parameter int CNT_WIDTH  = 12,
  parameter int CLR_CYCLES = 4,
  parameter int HOLDOFF    = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic overflow_in,
  input  logic underflow_in,
  input  logic rd_req,
  input  logic status_ack,
  output logic status_valid,
`ifdef FIFO_STATUS_TIMESTAMP_EN
  output logic [2*CNT_WIDTH+17:0] status_word,
`else
  output logic [2*CNT_WIDTH+1:0] status_word,
`endif
  output logic clear_out,
  output logic busy
);

  localparam int TMAX = (CLR_CYCLES > HOLDOFF) ? CLR_CYCLES : HOLDOFF;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_CLEAR, S_HOLD} state_t;

  state_t               state;
  logic [TW-1:0]        timer;
  logic                 ovf_q, unf_q;
  logic [CNT_WIDTH-1:0] ovf_cnt, unf_cnt;
  logic                 ovf_edge, unf_edge, take_snap;
  logic [CNT_WIDTH-1:0] ovf_next, unf_next;

  assign ovf_edge  = overflow_in & ~ovf_q;
  assign unf_edge  = underflow_in & ~unf_q;
  assign take_snap = (state == S_IDLE) && rd_req;

  // Saturating increment; the same value feeds the snapshot so an edge on the snapshot cycle is kept.
  assign ovf_next = (ovf_edge && (ovf_cnt != '1)) ? ovf_cnt + CNT_WIDTH'(1) : ovf_cnt;
  assign unf_next = (unf_edge && (unf_cnt != '1)) ? unf_cnt + CNT_WIDTH'(1) : unf_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else begin
      ovf_q <= overflow_in;
      unf_q <= underflow_in;
      if (take_snap) begin
        ovf_cnt <= '0;
        unf_cnt <= '0;
      end else begin
        ovf_cnt <= ovf_next;
        unf_cnt <= unf_next;
      end
    end
  end

`ifdef FIFO_STATUS_TIMESTAMP_EN
  logic [15:0] ts_cnt;
  logic [15:0] ovf_ts;
  logic        ts_seen;
  logic [15:0] ts_snap;

  assign ts_snap = ts_seen ? ovf_ts : (ovf_edge ? ts_cnt : 16'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt  <= '0;
      ovf_ts  <= '0;
      ts_seen <= 1'b0;
    end else begin
      ts_cnt <= ts_cnt + 16'd1;
      if (take_snap) begin
        ovf_ts  <= '0;
        ts_seen <= 1'b0;
      end else if (ovf_edge && !ts_seen) begin
        ovf_ts  <= ts_cnt;
        ts_seen <= 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      timer        <= '0;
      status_valid <= 1'b0;
      status_word  <= '0;
      clear_out    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rd_req) begin
            state        <= S_PRESENT;
            status_valid <= 1'b1;
            busy         <= 1'b1;
`ifdef FIFO_STATUS_TIMESTAMP_EN
            status_word  <= {overflow_in, underflow_in, ovf_next, unf_next, ts_snap};
`else
            status_word  <= {overflow_in, underflow_in, ovf_next, unf_next};
`endif
          end
        end
        S_PRESENT: begin
          if (status_ack) begin
            state        <= S_CLEAR;
            status_valid <= 1'b0;
            clear_out    <= 1'b1;
            timer        <= TW'(CLR_CYCLES - 1);
          end
        end
        S_CLEAR: begin
          if (timer == '0) begin
            state     <= S_HOLD;
            clear_out <= 1'b0;
            timer     <= TW'(HOLDOFF - 1);
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_HOLD: begin
          if (timer == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_status_reader.sv
// Randomized and directed bench for fifo_status_reader against a cycle-count based reference model.
module tb_fifo_status_reader;
  localparam int CW   = 4;
  localparam int CLR  = 4;
  localparam int HOLD = 8;
  localparam int WW   = 2*CW + 2;
`ifdef FIFO_STATUS_TIMESTAMP_EN
  localparam int SW = WW + 16;
`else
  localparam int SW = WW;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          overflow_in = 1'b0, underflow_in = 1'b0, rd_req = 1'b0, status_ack = 1'b0;
  logic          status_valid, clear_out, busy;
  logic [SW-1:0] status_word;

  fifo_status_reader #(.CNT_WIDTH(CW), .CLR_CYCLES(CLR), .HOLDOFF(HOLD)) dut (
    .clock(clock), .reset_n(reset_n), .overflow_in(overflow_in), .underflow_in(underflow_in),
    .rd_req(rd_req), .status_ack(status_ack), .status_valid(status_valid),
    .status_word(status_word), .clear_out(clear_out), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: event totals since last snapshot, edge numbers of the last read and ack.
  bit          m_prev_o, m_prev_u, m_active, m_acked;
  int          m_co, m_cu, m_e, m_rd_e, m_ack_e;
  logic [WW-1:0] m_word;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] sat(input int v);
    int lim = (1 << CW) - 1;
    return (v > lim) ? CW'(lim) : CW'(v);
  endfunction

  task automatic model_reset();
    m_prev_o = 0; m_prev_u = 0; m_active = 0; m_acked = 0;
    m_co = 0; m_cu = 0; m_e = 0; m_rd_e = 0; m_ack_e = 0; m_word = '0;
  endtask

  task automatic check_outputs();
    chk("valid", status_valid, m_active && !m_acked);
    chk("clear", clear_out, m_acked && (m_e >= m_ack_e) && (m_e < m_ack_e + CLR));
    chk("busy", busy, m_active && !(m_acked && (m_e >= m_ack_e + CLR + HOLD)));
    chk("word", status_word[SW-1 -: WW], m_word);
  endtask

  task automatic step(input bit o, input bit u, input bit r, input bit a);
    bit eo, eu, idle_b, pres_b;
    overflow_in = o; underflow_in = u; rd_req = r; status_ack = a;
    @(posedge clock);
    m_e++;
    eo = o && !m_prev_o;
    eu = u && !m_prev_u;
    idle_b = !m_active || (m_acked && (m_e >= m_ack_e + CLR + HOLD + 1));
    pres_b = m_active && !m_acked;
    if (r && idle_b) begin
      m_word = {o, u, sat(m_co + int'(eo)), sat(m_cu + int'(eu))};
      m_co = 0; m_cu = 0;
      m_active = 1; m_acked = 0; m_rd_e = m_e;
    end else begin
      m_co += int'(eo); m_cu += int'(eu);
      if (a && pres_b) begin
        m_acked = 1; m_ack_e = m_e;
      end
    end
    m_prev_o = o; m_prev_u = u;
    @(negedge clock);
    check_outputs();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    overflow_in = 0; underflow_in = 0; rd_req = 0; status_ack = 0;
    #1;
    chk("rst_clear", clear_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", status_valid, 1'b0);
    chk("rst_word", status_word, '0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) step(overflow_in, underflow_in, 1'b0, 1'b0);
  endtask

  initial begin
    bit co, cu;
    model_reset();
    @(negedge clock);
    do_reset();

    // read with nothing counted
    step(0, 0, 1, 0);
    chk("idle_word", status_word[SW-1 -: WW], '0);
    step(0, 0, 0, 1);
    idle_wait(CLR + HOLD);

    // 3 overflow edges, 1 underflow edge
    for (int i = 0; i < 3; i++) begin step(1, 0, 0, 0); step(0, 0, 0, 0); end
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("cnt_ovf3", status_word[SW-3 -: CW], 3);
    chk("cnt_unf1", status_word[SW-3-CW -: CW], 1);
    // ignored strobes in PRESENT, CLEAR and HOLD
    step(0, 0, 1, 0); step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < CLR + HOLD; i++) step(0, 0, 1, 1);
    step(0, 0, 0, 1); step(0, 0, 0, 1);

    // overflow edge on the snapshot cycle
    step(1, 0, 1, 0);
    chk("same_cyc_ovf", status_word[SW-3 -: CW], 1);
    chk("same_cyc_flag", status_word[SW-1], 1'b1);
    step(1, 0, 0, 1);
    idle_wait(CLR + HOLD);
    step(1, 0, 1, 0);
    chk("after_snap_ovf", status_word[SW-3 -: CW], 0);
    step(0, 0, 0, 1);
    idle_wait(CLR + HOLD);

    // saturation
    for (int i = 0; i < 20; i++) begin step(0, 1, 0, 0); step(0, 0, 0, 0); end
    step(0, 0, 1, 0);
    chk("sat_unf", status_word[SW-3-CW -: CW], 15);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    // in 2nd clear cycle, with an uncleared event pending
    #2;
    reset_n = 1'b0;
    #1;
    chk("midclr_clear", clear_out, 1'b0);
    chk("midclr_busy", busy, 1'b0);
    @(negedge clock);
    do_reset();
    step(0, 0, 1, 0);
    chk("postrst_ovf", status_word[SW-3 -: CW], 0);
    chk("postrst_unf", status_word[SW-3-CW -: CW], 0);
    step(0, 0, 0, 1);
    idle_wait(CLR + HOLD);

    // random traffic
    co = 0; cu = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(2) == 0) co = !co;
      if ($urandom_range(3) == 0) cu = !cu;
      step(co, cu, $urandom_range(3) == 0, $urandom_range(2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
